// File: rtl/burst_mem_responder_if.sv
// Request / write-beat / read-beat handshake bundle between a burst initiator (master)
// and the memory-side burst responder (slave).
interface burst_mem_responder_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_last;
  logic                  burst_done;

  modport master (
    output req_valid, req_write, req_addr, wdata_valid, wdata, rdata_ready,
    input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, burst_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, wdata_valid, wdata, rdata_ready,
    output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, burst_done
  );
endinterface

// File: rtl/burst_mem_responder.sv
// Burst memory responder: one request, then BURST_LEN beats against an internal register file.
// Define BURST_WRAP_EN for wrapping bursts (BURST_LEN-aligned window); default is incrementing.
module burst_mem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  burst_mem_responder_if.slave  bus
);
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam int OFS_W  = $clog2(BURST_LEN);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] cur;
  logic [ADDR_WIDTH-1:0] nxt;
  logic [BEAT_W-1:0]     beat;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

`ifdef BURST_WRAP_EN
  logic [ADDR_WIDTH-1:0] start_addr;

  function automatic logic [ADDR_WIDTH-1:0] wrap_next(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [ADDR_WIDTH-1:0] base);
    logic [OFS_W-1:0] ofs;
    ofs = a[OFS_W-1:0] + OFS_W'(1);
    return {base[ADDR_WIDTH-1:OFS_W], ofs};
  endfunction

  assign nxt = wrap_next(cur, start_addr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      start_addr <= '0;
    else if (state == IDLE && bus.req_valid)
      start_addr <= bus.req_addr;
  end
`else
  function automatic logic [ADDR_WIDTH-1:0] incr_next(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_WIDTH'(1);
  endfunction

  assign nxt = incr_next(cur);
`endif

  // req_ready is gated by rstn so it reads 0 while reset is held, 1 as soon as it lifts
  assign bus.req_ready   = rstn && (state == IDLE);
  assign bus.wdata_ready = (state == WRITE);
  assign bus.rdata_valid = (state == READ);
  assign bus.rdata       = rdata_q;
  assign bus.rdata_last  = (state == READ) && (beat == LAST_BEAT);
  assign bus.burst_done  = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cur     <= '0;
      beat    <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cur   <= bus.req_addr;
            beat  <= '0;
            state <= bus.req_write ? WRITE : READ;
            // Preload the first read beat so it is valid in the first READ cycle
            if (!bus.req_write)
              rdata_q <= mem[bus.req_addr[IDX_W-1:0]];
          end
        end
        WRITE: begin
          if (bus.wdata_valid) begin
            cur  <= nxt;
            beat <= beat + BEAT_W'(1);
            if (beat == LAST_BEAT)
              state <= DONE;
          end
        end
        READ: begin
          if (bus.rdata_ready) begin
            cur     <= nxt;
            beat    <= beat + BEAT_W'(1);
            rdata_q <= mem[nxt[IDX_W-1:0]];
            if (beat == LAST_BEAT)
              state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; beats written before a mid-burst reset survive
  always_ff @(posedge clk) begin
    if (state == WRITE && bus.wdata_valid)
      mem[cur[IDX_W-1:0]] <= bus.wdata;
  end
endmodule

// File: tb/tb_burst_mem_responder.sv
// Self-checking bench for burst_mem_responder: memory model feeds a queue of expected read beats.
module tb_burst_mem_responder;
  localparam int BL = 8;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] model [int];
  exp_t        sb [$];

  always #5 clk = ~clk;

  burst_mem_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  burst_mem_responder #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .BURST_LEN(BL), .MEM_DEPTH(256)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  function automatic int idx_of(input logic [15:0] start, input int i);
    logic [15:0] a;
`ifdef BURST_WRAP_EN
    a = (start & 16'hFFF8) | ((start + 16'(i)) & 16'h0007);
`else
    a = start + 16'(i);
`endif
    return int'(a[7:0]);
  endfunction

  task automatic issue_req(input logic wr, input logic [15:0] addr, output int waits, output bit ok);
    waits = 0;
    ok = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    while (bus.req_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    tests++;
    if (bus.req_ready !== 1'b1) begin
      $display("FAIL req_accept: req_ready=%b required 1 within 20 cycles", bus.req_ready);
      fails++;
      bus.req_valid = 1'b0;
    end else begin
      ok = 1'b1;
    end
    @(posedge clk);
  endtask

  // Ends at the negedge of the DONE cycle (full burst) or of the cycle after the last driven beat
  task automatic write_burst(input logic [15:0] addr, input logic [31:0] base, input int nbeats);
    int waits;
    bit ok;
    issue_req(1'b1, addr, waits, ok);
    if (!ok) return;
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      if (i == 0) bus.req_valid = 1'b0;
      tests++;
      if (bus.wdata_ready !== 1'b1) begin
        $display("FAIL wdata_ready beat %0d: got %b required 1", i, bus.wdata_ready);
        fails++;
      end
      bus.wdata_valid = 1'b1;
      bus.wdata       = base + 32'(i);
      model[idx_of(addr, i)] = base + 32'(i);
    end
    @(negedge clk);
    bus.wdata_valid = 1'b0;
    if (nbeats == BL) begin
      tests++;
      if (bus.burst_done !== 1'b1 || bus.wdata_ready !== 1'b0) begin
        $display("FAIL write_done: burst_done=%b wdata_ready=%b required 1/0",
                 bus.burst_done, bus.wdata_ready);
        fails++;
      end
    end
  endtask

  task automatic read_burst(input logic [15:0] addr, input bit stall, input bit keep, output int waits);
    bit   ok;
    int   got;
    int   cyc;
    logic rdy;
    exp_t e;
    issue_req(1'b0, addr, waits, ok);
    if (!ok) return;
    for (int i = 0; i < BL; i++) begin
      e.data = model.exists(idx_of(addr, i)) ? model[idx_of(addr, i)] : 32'hDEAD_BEEF;
      e.last = (i == BL - 1);
      sb.push_back(e);
    end
    got = 0;
    cyc = 0;
    while (got < BL && cyc < 4 * BL) begin
      @(negedge clk);
      cyc++;
      if (!keep) bus.req_valid = 1'b0;
      tests++;
      if (bus.rdata_valid !== 1'b1 || bus.rdata !== sb[0].data || bus.rdata_last !== sb[0].last) begin
        $display("FAIL read_beat %0d @0x%h: valid=%b data=0x%h last=%b required 1/0x%h/%b",
                 got, addr, bus.rdata_valid, bus.rdata, bus.rdata_last, sb[0].data, sb[0].last);
        fails++;
      end
      tests++;
      if (bus.req_ready !== 1'b0) begin
        $display("FAIL req_ready_busy: got %b required 0", bus.req_ready);
        fails++;
      end
      rdy = stall ? logic'(cyc % 2) : 1'b1;
      bus.rdata_ready = rdy;
      if (rdy) begin
        void'(sb.pop_front());
        got++;
      end
    end
    sb.delete();
    tests++;
    if (got != BL) begin
      $display("FAIL read_timeout: %0d handshakes required %0d", got, BL);
      fails++;
    end
    @(negedge clk);
    bus.rdata_ready = 1'b0;
    tests++;
    if (bus.burst_done !== 1'b1 || bus.rdata_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      $display("FAIL read_done: burst_done=%b rdata_valid=%b req_ready=%b required 1/0/0",
               bus.burst_done, bus.rdata_valid, bus.req_ready);
      fails++;
    end
    if (!stall) begin
      tests++;
      if (cyc != BL) begin
        $display("FAIL read_throughput: %0d cycles required %0d", cyc, BL);
        fails++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (bus.req_ready !== 1'b0 || bus.wdata_ready !== 1'b0 || bus.rdata_valid !== 1'b0 ||
        bus.rdata !== 32'h0 || bus.rdata_last !== 1'b0 || bus.burst_done !== 1'b0) begin
      $display("FAIL %s: req_ready=%b wdata_ready=%b rdata_valid=%b rdata=0x%h last=%b done=%b required all 0",
               tag, bus.req_ready, bus.wdata_ready, bus.rdata_valid, bus.rdata,
               bus.rdata_last, bus.burst_done);
      fails++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_reset_outputs("reset_values");
    rstn = 1'b1;
    #1;
    tests++;
    if (bus.req_ready !== 1'b1) begin
      $display("FAIL reset_release_ready: got %b required 1", bus.req_ready);
      fails++;
    end
  endtask

  task automatic test_write_read();
    int waits;
    write_burst(16'h0010, 32'hA0, BL);
    read_burst(16'h0010, 1'b0, 1'b0, waits);
  endtask

  task automatic test_read_stall();
    int waits;
    read_burst(16'h0010, 1'b1, 1'b0, waits);
  endtask

  task automatic test_wrap();
    int waits;
    write_burst(16'h0006, 32'hC0, BL);
`ifdef BURST_WRAP_EN
    read_burst(16'h0000, 1'b0, 1'b0, waits);
`else
    read_burst(16'h0006, 1'b0, 1'b0, waits);
`endif
  endtask

  task automatic test_addr_rollover();
    int waits;
    write_burst(16'hFFFC, 32'hD0, BL);
    read_burst(16'hFFFC, 1'b1, 1'b0, waits);
  endtask

  task automatic test_reset_mid_burst();
    int waits;
    write_burst(16'h0040, 32'h5000, BL);
    write_burst(16'h0040, 32'h6000, 3);
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_burst_reset");
    @(negedge clk);
    check_reset_outputs("mid_burst_reset_hold");
    rstn = 1'b1;
    read_burst(16'h0040, 1'b0, 1'b0, waits);
    tests++;
    if (waits != 0) begin
      $display("FAIL post_reset_accept: waited %0d cycles required 0", waits);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    int waits;
    read_burst(16'h0010, 1'b0, 1'b1, waits);
    read_burst(16'h0006, 1'b0, 1'b0, waits);
    tests++;
    if (waits != 0) begin
      $display("FAIL back_to_back_accept: waited %0d cycles required 0", waits);
      fails++;
    end
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.rdata_ready = 1'b0;
    test_reset();
    test_write_read();
    test_read_stall();
    test_wrap();
    test_addr_rollover();
    test_reset_mid_burst();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/burst_mem_responder.md
# burst_mem_responder

Memory-side target for the burst address path: accepts one burst request (start address, direction), then services exactly BURST_LEN data beats against an internal register-file memory, generating the per-beat addresses itself. It sits at the far end of the burst initiator, which drives the request and then streams write data or sinks read data over valid/ready handshakes.

## Interface
- ADDR_WIDTH, 16, request address width
- DATA_WIDTH, 32, beat data width
- BURST_LEN, 8, beats per burst; power of two, 2..16
- MEM_DEPTH, 256, memory words; power of two, ≤ 2^ADDR_WIDTH
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  burst request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_WIDTH  burst start address
- wdata_valid  in  1  write beat present
- wdata_ready  out  1  responder accepts write beat
- wdata  in  DATA_WIDTH  write beat data
- rdata_valid  out  1  read beat present
- rdata_ready  in  1  initiator accepts read beat
- rdata  out  DATA_WIDTH  read beat data
- rdata_last  out  1  current read beat is beat BURST_LEN-1
- burst_done  out  1  one-cycle pulse when a burst completes

## Operation
- States: IDLE, WRITE, READ, DONE. Reset → IDLE.
- IDLE: req_ready=1. On req_valid&req_ready: latch start=req_addr, cur=req_addr, beat=0; go WRITE if req_write else READ.
- WRITE: wdata_ready=1. Each wdata_valid&wdata_ready writes mem[cur mod MEM_DEPTH]=wdata, beat++, cur=next(cur). On beat BURST_LEN-1 handshake → DONE.
- READ: rdata is a registered copy of mem[cur mod MEM_DEPTH]; rdata_valid=1 for whole state. On rdata_valid&rdata_ready: beat++, cur=next(cur), rdata reloads from new address. rdata_last=1 when beat==BURST_LEN-1. That handshake → DONE.
- DONE: burst_done=1 for one cycle, req_ready=0, → IDLE.
- Stalls: deasserted wdata_valid/rdata_ready hold state, beat, cur, rdata stable; no timeout.
- Address arithmetic: next(cur) per Configuration; linear increment is modulo 2^ADDR_WIDTH (0xFFFF → 0x0000 at default width). Memory index = low log2(MEM_DEPTH) bits of cur.
- beat counter width $clog2(BURST_LEN)+1; beat never exceeds BURST_LEN-1 in WRITE/READ.
- Memory contents are not reset; all control registers are.
- Reset mid-burst: immediate return to IDLE, partial write beats already stored remain, no burst_done.

## Timing
- Reset values: req_ready=0 during reset, 1 in first IDLE cycle after release; wdata_ready=0, rdata_valid=0, rdata=0, rdata_last=0, burst_done=0.
- Request accepted cycle T → WRITE/READ at T+1; first read beat valid at T+1 with data of start address.
- Read: one beat per cycle at full throughput when rdata_ready held high; burst of 8 occupies T+1..T+8, burst_done at T+9, next request acceptable T+10.
- Write: beat accepted same cycle as wdata_valid; data readable by a later read burst.
- req_ready=0 outside IDLE; requests presented then are not consumed.

## Configuration
- BURST_WRAP_EN defined: wrapping bursts; next(cur) increments only the low $clog2(BURST_LEN) bits, upper bits fixed at start's, so addresses stay within the BURST_LEN-aligned window (start 0x0006, len 8 → 6,7,0,1,2,3,4,5).
- Undefined: incrementing bursts; next(cur)=cur+1 modulo 2^ADDR_WIDTH (start 0x0006 → 6..13).

## Test plan
- Write burst at 0x0010, data 0xA0..0xA7 back-to-back, then read burst 0x0010 with rdata_ready=1 → rdata 0xA0..0xA7 on consecutive cycles, rdata_last on 0xA7, burst_done one cycle after.
- Read burst with rdata_ready toggling 1/0 → each beat held stable while stalled, exactly 8 handshakes, no beat lost or duplicated.
- Write at start 0x0006 then read 0x0000 (BURST_WRAP_EN defined) → locations 0..7 hold beats 2..7,0..1 order per wrap; undefined → data at 6..13.
- Start 0xFFFC, incrementing build, MEM_DEPTH 256 → indices 0xFC..0xFF,0x00..0x03 written; cur wraps to 0x0000.
- Assert rstn low at write beat 3 → outputs to reset values next cycle; new read request accepted after release; beats 0..2 visible in memory.
- req_valid held high during active burst → second request accepted only in IDLE after burst_done.
